// File: rtl/vga_fb_reader.sv
// Display-side reader for the 320x240 RGB444 frame buffer: 640x480@60 VGA timing,
// buffer read-port addressing and a two-clock counter-to-pin pipeline.
module vga_fb_reader #(
    parameter int UPSCALE  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic        oe,
    output logic [16:0] rAddr,
    input  logic [11:0] rData,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SRC_W   = H_ACTIVE / 2;
    localparam int SRC_H   = V_ACTIVE / 2;
    localparam int VIS_W   = (UPSCALE == 2) ? H_ACTIVE : SRC_W;
    localparam int VIS_H   = (UPSCALE == 2) ? V_ACTIVE : SRC_H;
    localparam bit DOUBLE  = (UPSCALE == 2);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  H_VIS     = 10'(VIS_W);
    localparam logic [9:0]  V_VIS     = 10'(VIS_H);
    localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0] LINE_STEP = 17'(SRC_W);

    logic [9:0]  h_cnt_p0;
    logic [9:0]  v_cnt_p0;
    logic [9:0]  col_p0;
    logic [16:0] line_base_p0;
    logic        h_wrap_p0;
    logic        v_wrap_p0;
    logic        active_p0;
    logic        visible_p0;
    logic        hsync_raw_p0;
    logic        vsync_raw_p0;
    logic        fs_p0;

    logic        hsync_p1;
    logic        vsync_p1;
    logic        de_p1;
    logic        fs_p1;
    logic        vld_p2;

    function automatic logic [11:0] blank_px(input logic vld, input logic [11:0] px);
        return vld ? px : 12'd0;
    endfunction

    // ---- stage 0: pixel counters and incremental source address ----
    always_comb begin
        h_wrap_p0    = (h_cnt_p0 == H_LAST);
        v_wrap_p0    = (v_cnt_p0 == V_LAST);
        active_p0    = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
        visible_p0   = (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
        hsync_raw_p0 = !((h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END));
        vsync_raw_p0 = !((v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END));
        fs_p0        = (h_cnt_p0 == 10'd0) && (v_cnt_p0 == 10'd0);
    end

    // line_base stops advancing past the last visible source line so it never exceeds 17 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_p0     <= '0;
            v_cnt_p0     <= '0;
            col_p0       <= '0;
            line_base_p0 <= '0;
        end else if (h_wrap_p0) begin
            h_cnt_p0 <= '0;
            col_p0   <= '0;
            if (v_wrap_p0) begin
                v_cnt_p0     <= '0;
                line_base_p0 <= '0;
            end else begin
                v_cnt_p0 <= v_cnt_p0 + 10'd1;
                if ((v_cnt_p0 < V_VIS) && (!DOUBLE || v_cnt_p0[0]))
                    line_base_p0 <= line_base_p0 + LINE_STEP;
            end
        end else begin
            h_cnt_p0 <= h_cnt_p0 + 10'd1;
            if (!DOUBLE || h_cnt_p0[0])
                col_p0 <= col_p0 + 10'd1;
        end
    end

    // ---- stage 1: buffer read request ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe       <= 1'b0;
            rAddr    <= '0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            de_p1    <= 1'b0;
            fs_p1    <= 1'b0;
        end else begin
            oe       <= en && visible_p0;
            if (visible_p0)
                rAddr <= line_base_p0 + {7'd0, col_p0};
            hsync_p1 <= hsync_raw_p0;
            vsync_p1 <= vsync_raw_p0;
            de_p1    <= active_p0;
            fs_p1    <= fs_p0;
        end
    end

    // ---- stage 2: read data returns; pins ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2      <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vld_p2      <= oe;
            hsync       <= hsync_p1;
            vsync       <= vsync_p1;
            de          <= de_p1;
            frame_start <= fs_p1;
        end
    end

    // rData arrives one clock after rAddr, i.e. in step with the stage-2 registers
    assign {red, green, blue} = blank_px(vld_p2, rData);

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Display-side reader for the 320x240 RGB444 frame buffer: generates 640x480@60 VGA timing and drives the buffer's read port (oe, rAddr).
- Accepts rData with one-clock RAM read latency and emits aligned 4:4:4 RGB, syncs and data-enable to the VGA pins.
- Runs on the 25 MHz pixel clock, which is also the buffer's rclk.
- Complements the camera capture path that fills the buffer's write port.

Parameters:
- UPSCALE, 2, 2 = pixel- and line-double 320x240 to fill 640x480; 1 = native 320x240 window at top-left, black elsewhere.
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels (total 800).
- V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines (total 525).

Ports:
- clk  in  1  pixel clock (25 MHz), also the frame buffer rclk.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; low forces black and oe=0, but timing keeps running.
- oe  out  1  frame buffer read enable.
- rAddr  out  17  frame buffer read address.
- rData  in  12  frame buffer read data {R[11:8],G[7:4],B[3:0]}, valid one clk after the address.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- de  out  1  active-video flag aligned with the RGB outputs.
- red, green, blue  out  4 each  pixel colour; 0 when de=0.
- frame_start  out  1  one-clk pulse aligned with the first active pixel (x=0, y=0) on the outputs.

Behaviour:
- Reset (async, reset_n=0):
  - h_cnt=0, v_cnt=0.
  - oe=0, rAddr=0.
  - hsync=1, vsync=1, de=0, red/green/blue=0, frame_start=0.
  - Pipeline registers are cleared.
  - Release is synchronous to clk; the first counted pixel is h=0,v=0.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..524 and wraps to 0.
- Active region: h_cnt<640 && v_cnt<480.
- Sync windows (stage 0):
  - hsync_raw is low for h_cnt in 656..751.
  - vsync_raw is low for v_cnt in 490..491, for the whole line.
- Stage 1 (registered from stage 0):
  - oe = en && visible. visible = active for UPSCALE=2; for UPSCALE=1, visible = h_cnt<320 && v_cnt<240.
  - rAddr:
    - UPSCALE=2: (v_cnt>>1)*320 + (h_cnt>>1).
    - UPSCALE=1: v_cnt*320 + h_cnt.
    - When visible=0, rAddr holds its last value.
  - Address arithmetic is incremental, with no multiplier:
    - a line-base register adds 320 at the start of each new source line (every 2nd line for UPSCALE=2) and clears at v wrap;
    - a column offset adds 1 every 2nd pixel (UPSCALE=2) or every pixel (UPSCALE=1) and clears at h wrap.
  - Maximum address is 76799; 17 bits, no overflow.
- Stage 2: rData is valid (RAM latency 1).
  - red/green/blue = rData fields when the delayed oe=1, else 0.
  - hsync, vsync, de and frame_start are the stage-0 values delayed by exactly 2 clks, so every output is mutually aligned.
  - Total latency from counter value to pins is 2 clks.
- de follows active (640x480) regardless of UPSCALE and en; the non-visible part is black with de=1.
- en deasserted mid-line takes effect per pixel with the same 2-clk latency; no tearing state is kept.
- Reset mid-frame aborts the frame immediately and restarts timing from h=0,v=0. The buffer contents are not touched.

Test Plan:
- Reset, then run one full frame: 800 clks per line and 420000 clks per frame.
  - Required: hsync low for 96 clks starting at the 657th clk of each line.
  - Required: vsync low for exactly 1600 clks.
- UPSCALE=2, RAM model returns rData = low 12 bits of the previous address.
  - Required: the first 4 active pixels show addresses 0,0,1,1.
  - Required: line 1 repeats line 0; line 2 starts at 320.
  - Required: last active pixel (639,479) reads rAddr=76799.
- Alignment check.
  - Required: frame_start, de rise and the first RGB of rData(addr 0) all appear on the same clk, 2 clks after h_cnt=0,v_cnt=0.
- UPSCALE=1.
  - Required: pixel (319,239) reads 76799.
  - Required: for (320..639, any row) and rows 240..479, oe=0, de=1 and RGB=0.
- en=0 for pixels 100..199 of line 10.
  - Required: oe low for those 100 clks and RGB=0 on the matching output window.
  - Required: sync timing is unchanged.
- Assert reset_n low at h=300,v=200 for 3 clks.
  - Required: all outputs go to reset values asynchronously.
  - Required: after release, frame_start appears 2 clks after the counters restart.
